v810_prefetch: RTL
==================

# v810_prefetch

Instruction prefetch queue sitting directly upstream of `v810_exec`. It fetches 32-bit words from instruction memory into a halfword queue, assembles 16- and 32-bit V810 instructions at any halfword alignment, and presents one complete instruction at a time together with its address. It also services branch redirects from the execute stage by flushing the queue and restarting the fetch.

## Interface
Parameters:
- `DEPTH`, 8: queue capacity in halfwords; a power of two, ≥ 4.
- `RESET_PC`, 32'h0000_0000: fetch address after reset.

Ports:
- `CLK`  in  1  clock.
- `RES`  in  1  reset, synchronous, active-high.
- `CE`  in  1  clock enable; when low, all state holds.
- `MA`  out  32  fetch word address; bits [1:0] are always 0.
- `MREQ`  out  1  fetch request; memory accepts every request.
- `MD`  in  32  fetch data, valid in the cycle after the request; halfword at MA in [15:0], MA+2 in [31:16].
- `IR`  out  32  instruction; first halfword in [15:0], second in [31:16] (second is don't-care for 16-bit).
- `IPC`  out  32  address of IR; bit 0 is always 0.
- `ILEN`  out  1  0 = 16-bit, 1 = 32-bit.
- `IVALID`  out  1  IR/IPC/ILEN valid.
- `ITAKE`  in  1  exec consumes the current instruction; ignored unless IVALID is high.
- `JMP`  in  1  redirect request.
- `JA`  in  32  redirect target; bit 0 is ignored (treated as 0).

## Operation
- Circular buffer of DEPTH halfwords with read pointer, write pointer and count. A separate `fpc` register holds the next word to fetch; `ipc` holds the address of the queue head.
- Length decode on the head halfword h: ILEN = (h[15:13]==3'b101) | (h[15:14]==2'b11), i.e. opcode ≥ 6'h28.
- IVALID = count ≥ (ILEN ? 2 : 1).
- Issue rule: MREQ = CE & ~RES & (DEPTH − count − 2·inflight ≥ 2). inflight is 0 or 1. On issue, fpc advances by 4.
- Return: in the cycle after an issue, MD is written as 2 halfwords, or as 1 halfword ([31:16] only) when the word is the first after a redirect to a target with JA[1]=1. Return capture happens regardless of CE.
- Consume: on CE & ITAKE & IVALID, the read pointer, count and ipc advance by 1 or 2 halfwords (ipc by 2 or 4). The same-cycle write and consume combine; count never overflows because of the issue rule.
- Redirect, CE & JMP:
  - count is set to 0 and ipc ← JA & ~1; fpc ← JA & ~3.
  - Any return arriving next cycle is squashed.
  - MREQ is forced low during the JMP cycle.
  - JMP wins over a simultaneous ITAKE and over a simultaneous return.
- Addresses wrap modulo 2^32 without special handling.
- Reset (RES=1 at CLK edge): count=0, inflight=0, ipc=fpc=RESET_PC, squash cleared. Output values in reset: IVALID=0, MREQ=0, MA=RESET_PC, IPC=RESET_PC, IR=0.

## Timing
- First cycle after RES falls (CE=1): MREQ=1, MA=RESET_PC. Data is captured the next edge; IVALID rises 2 cycles after the request.
- Steady state: one word per cycle while space allows. A stream of 16-bit instructions starves once consumption exceeds 2 halfwords/cycle; this never happens, since exec takes at most one instruction per cycle.
- Redirect: JMP in cycle N → MREQ with MA=JA&~3 in N+1 → IVALID in N+3.
- A 32-bit instruction at JA[1]=1 needs 2 words: IVALID in N+4.
- IR/IPC/ILEN are stable while IVALID=1 and ITAKE=0.

## Configuration
- `V810_PREFETCH_BYPASS_EN` defined: when the queue is empty and the returning word completes an instruction, that instruction is forwarded combinationally from MD. IVALID then rises in the return cycle, saving one cycle: reset-to-valid and redirect-to-valid each drop by 1. The same instruction is also written to the queue unless it is consumed that cycle.
- Not defined: IR is driven only from queue registers; the latencies are as stated in Timing.

## Test plan
- Reset, then imem holding sequential 16-bit `mov` at 0..: MREQ at MA=0,4,8…; IVALID at cycle 2 with IPC=0, ILEN=0; with ITAKE held high, IPC steps 0,2,4… with no bubbles.
- Mixed stream: 16-bit at 0, 32-bit `movea` at 2, 16-bit at 6 → IR for IPC=2 = {hw@4, hw@2}, ILEN=1; next IPC=6.
- ITAKE held low: queue fills to DEPTH, MREQ drops with inflight counted, and no halfword is lost or duplicated when ITAKE resumes.
- JMP to 0x102 in the same cycle as a return and as ITAKE: returned word discarded; next MA=0x100; first IVALID has IPC=0x102, taken from MD[31:16] of word 0x100.
- 32-bit instruction at 0x1FE after redirect: IVALID only after words 0x1FC and 0x200 have both returned; IR = {hw@0x200, hw@0x1FE}.
- CE low for 3 cycles mid-stream: MREQ=0, outputs frozen, the in-flight word is still captured, and the stream resumes unchanged.

Source files
------------

// File: rtl/v810_prefetch_if.sv
// Fetch-side and execute-side signals of the V810 instruction prefetch queue.
// master = prefetch unit, slave = memory/execute environment.
interface v810_prefetch_if;
  logic [31:0] MA;
  logic        MREQ;
  logic [31:0] MD;
  logic [31:0] IR;
  logic [31:0] IPC;
  logic        ILEN;
  logic        IVALID;
  logic        ITAKE;
  logic        JMP;
  logic [31:0] JA;

  modport master (
    output MA, MREQ, IR, IPC, ILEN, IVALID,
    input  MD, ITAKE, JMP, JA
  );

  modport slave (
    input  MA, MREQ, IR, IPC, ILEN, IVALID,
    output MD, ITAKE, JMP, JA
  );
endinterface

// File: rtl/v810_prefetch.sv
// V810 instruction prefetch queue: word fetch into a halfword ring, 16/32-bit assembly, redirect flush.
// Optional macro V810_PREFETCH_BYPASS_EN forwards a completing return word straight to IR when the queue is empty.
module v810_prefetch #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           CLK,
  input logic           RES,
  input logic           CE,
  v810_prefetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  typedef logic [AW+1:0] need_t;

  localparam need_t LIMIT = need_t'(DEPTH - 2);

  function automatic logic f_is_long(input logic [15:0] h);
    return (h[15:13] == 3'b101) | (h[15:14] == 2'b11);
  endfunction

  logic [15:0] r_q [DEPTH];
  ptr_t        r_rptr, r_wptr;
  cnt_t        r_count;
  logic        r_inflight, r_squash, r_half;
  logic [31:0] r_fpc, r_ipc;

  logic        w_jmp, w_ret, w_wr, w_mreq, w_len, w_ivalid, w_take, w_unused;
  need_t       w_need;
  cnt_t        w_add, w_sub, w_avail;
  ptr_t        w_rptr1, w_wptr1;
  logic [15:0] w_h0, w_h1;

  assign w_jmp    = CE & bus.JMP;
  assign w_ret    = r_inflight & ~r_squash;
  assign w_wr     = w_ret & ~w_jmp;
  assign w_rptr1  = r_rptr + ptr_t'(1);
  assign w_wptr1  = r_wptr + ptr_t'(1);
  assign w_unused = bus.JA[0];

  // Space must cover the current fill plus the word still on its way back.
  assign w_need = need_t'(r_count) + (r_inflight ? need_t'(2) : need_t'(0));
  assign w_mreq = CE & ~RES & ~w_jmp & (w_need <= LIMIT);

`ifdef V810_PREFETCH_BYPASS_EN
  logic w_byp;
  assign w_byp   = w_wr & (r_count == '0) & (~r_half | ~f_is_long(bus.MD[31:16]));
  assign w_h0    = w_byp ? (r_half ? bus.MD[31:16] : bus.MD[15:0]) : r_q[r_rptr];
  assign w_h1    = w_byp ? bus.MD[31:16] : r_q[w_rptr1];
  assign w_avail = w_byp ? (r_half ? cnt_t'(1) : cnt_t'(2)) : r_count;
`else
  assign w_h0    = r_q[r_rptr];
  assign w_h1    = r_q[w_rptr1];
  assign w_avail = r_count;
`endif

  assign w_len    = f_is_long(w_h0);
  assign w_ivalid = ~RES & ((w_avail >= cnt_t'(2)) | ((w_avail == cnt_t'(1)) & ~w_len));
  assign w_take   = CE & bus.ITAKE & w_ivalid & ~bus.JMP;
  assign w_add    = ~w_wr   ? '0 : (r_half ? cnt_t'(1) : cnt_t'(2));
  assign w_sub    = ~w_take ? '0 : (w_len  ? cnt_t'(2) : cnt_t'(1));

  assign bus.MA     = r_fpc;
  assign bus.MREQ   = w_mreq;
  assign bus.IPC    = r_ipc;
  assign bus.ILEN   = w_ivalid & w_len;
  assign bus.IVALID = w_ivalid;
  assign bus.IR     = w_ivalid ? {w_h1, w_h0} : 32'h0;

  // Queue storage: a word after a redirect to an odd halfword keeps only its upper half.
  always_ff @(posedge CLK) begin
    if (w_wr) begin
      if (r_half) begin
        r_q[r_wptr] <= bus.MD[31:16];
      end else begin
        r_q[r_wptr]  <= bus.MD[15:0];
        r_q[w_wptr1] <= bus.MD[31:16];
      end
    end
  end

  // Control: returns are captured even with CE low, everything else holds.
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_squash   <= 1'b0;
      r_half     <= 1'b0;
      r_fpc      <= RESET_PC;
      r_ipc      <= RESET_PC;
    end else begin
      r_inflight <= w_mreq;
      r_squash   <= w_jmp;
      if (w_jmp) begin
        r_rptr  <= '0;
        r_wptr  <= '0;
        r_count <= '0;
        r_half  <= bus.JA[1];
        r_ipc   <= {bus.JA[31:1], 1'b0};
        r_fpc   <= {bus.JA[31:2], 2'b00};
      end else begin
        r_count <= r_count + w_add - w_sub;
        if (w_wr) begin
          r_wptr <= r_wptr + ptr_t'(w_add);
          r_half <= 1'b0;
        end
        if (w_take) begin
          r_rptr <= r_rptr + ptr_t'(w_sub);
          r_ipc  <= r_ipc + (w_len ? 32'd4 : 32'd2);
        end
        if (w_mreq) r_fpc <= r_fpc + 32'd4;
      end
    end
  end
endmodule
